// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button synchroniser, debounce, press/release pulses and
// hold-to-auto-repeat events for the raw board push-buttons feeding cylon_top.
module btn_conditioner #(
  parameter int unsigned      N_BTN           = 3,
  // 26 bits so the 0.5 s default repeat delay at 100 MHz is representable
  parameter int unsigned      CNT_W           = 26,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = CNT_W'(1_000_000),
  parameter logic [CNT_W-1:0] REPEAT_DELAY    = CNT_W'(50_000_000),
  parameter logic [CNT_W-1:0] REPEAT_PERIOD   = CNT_W'(10_000_000)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_event
);

  localparam logic [1:0] RELEASED   = 2'd0;
  localparam logic [1:0] PRESS_PEND = 2'd1;
  localparam logic [1:0] PRESSED    = 2'd2;
  localparam logic [1:0] REL_PEND   = 2'd3;

  // A single stable sample is enough to accept a level change
  localparam logic ONE_SHOT = (DEBOUNCE_CYCLES == CNT_W'(1));
  localparam logic REP_EN   = (REPEAT_DELAY != '0);

  logic [N_BTN-1:0] sync0;
  logic [N_BTN-1:0] sync1;

  // Two-flop synchroniser for the asynchronous button pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= btn_in;
      sync1 <= sync0;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rcnt;
    logic             rep_started;
    logic             level_r;
    logic             press_r;
    logic             release_r;
    logic             event_r;
    logic             s;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rcnt_inc;
    logic [CNT_W-1:0] rep_target;

    // Next-count values and the current repeat interval (first delay, then period)
    always_comb begin
      s          = sync1[g];
      cnt_inc    = cnt + CNT_W'(1);
      rcnt_inc   = rcnt + CNT_W'(1);
      rep_target = rep_started ? REPEAT_PERIOD : REPEAT_DELAY;
    end

    // Debounce FSM; a change is accepted on the edge that sees the
    // DEBOUNCE_CYCLES-th consecutive stable sample, so the entry sample counts as 1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state       <= RELEASED;
        cnt         <= '0;
        rcnt        <= '0;
        rep_started <= 1'b0;
        level_r     <= 1'b0;
        press_r     <= 1'b0;
        release_r   <= 1'b0;
        event_r     <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        event_r   <= 1'b0;
        case (state)
          RELEASED: begin
            if (s) begin
              if (ONE_SHOT) begin
                state       <= PRESSED;
                cnt         <= '0;
                press_r     <= 1'b1;
                event_r     <= 1'b1;
                level_r     <= 1'b1;
                rcnt        <= '0;
                rep_started <= 1'b0;
              end else begin
                state <= PRESS_PEND;
                cnt   <= CNT_W'(1);
              end
            end
          end
          PRESS_PEND: begin
            if (!s) begin
              state <= RELEASED;
              cnt   <= '0;
            end else if (cnt_inc == DEBOUNCE_CYCLES) begin
              state       <= PRESSED;
              cnt         <= '0;
              press_r     <= 1'b1;
              event_r     <= 1'b1;
              level_r     <= 1'b1;
              rcnt        <= '0;
              rep_started <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          PRESSED: begin
            if (!s) begin
              if (ONE_SHOT) begin
                state     <= RELEASED;
                cnt       <= '0;
                release_r <= 1'b1;
                level_r   <= 1'b0;
              end else begin
                state <= REL_PEND;
                cnt   <= CNT_W'(1);
              end
            end else if (REP_EN) begin
              if (rcnt_inc == rep_target) begin
                event_r     <= 1'b1;
                rcnt        <= '0;
                rep_started <= 1'b1;
              end else begin
                rcnt <= rcnt_inc;
              end
            end
          end
          REL_PEND: begin
            if (s) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt_inc == DEBOUNCE_CYCLES) begin
              state     <= RELEASED;
              cnt       <= '0;
              release_r <= 1'b1;
              level_r   <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= RELEASED;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign btn_level[g]   = level_r;
    assign btn_press[g]   = press_r;
    assign btn_release[g] = release_r;
    assign btn_event[g]   = event_r;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: scoreboard bench for btn_conditioner with short debounce
// and repeat timings; a second instance has auto-repeat disabled.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] btn_in;
  logic [2:0] btn_level, btn_press, btn_release, btn_event;
  logic [2:0] btn_in_nr;
  logic [2:0] nr_level, nr_press, nr_release, nr_event;

  btn_conditioner #(
    .N_BTN(3),
    .CNT_W(26),
    .DEBOUNCE_CYCLES(26'd4),
    .REPEAT_DELAY(26'd20),
    .REPEAT_PERIOD(26'd8)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_event(btn_event)
  );

  btn_conditioner #(
    .N_BTN(3),
    .CNT_W(26),
    .DEBOUNCE_CYCLES(26'd4),
    .REPEAT_DELAY(26'd0),
    .REPEAT_PERIOD(26'd8)
  ) u_nr (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in_nr),
    .btn_level(nr_level),
    .btn_press(nr_press),
    .btn_release(nr_release),
    .btn_event(nr_event)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] evt;
    logic [2:0] level;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int nr_press_cnt = 0;
  int nr_evt_cnt   = 0;
  int nr_rel_cnt   = 0;
  int nr_noncoin   = 0;
  int nr_press_cyc = -1;

  // Insert an expected output cycle, keeping the queue ordered and merging
  // events of different channels that land on the same cycle
  function automatic void push(int c, logic [2:0] p, logic [2:0] r,
                               logic [2:0] e, logic [2:0] l);
    exp_t x;
    int   pos;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc == c) begin
        sb[i].press = sb[i].press | p;
        sb[i].rel   = sb[i].rel | r;
        sb[i].evt   = sb[i].evt | e;
        sb[i].level = l;
        return;
      end
    end
    x.cyc = c; x.press = p; x.rel = r; x.evt = e; x.level = l;
    pos = sb.size();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc > c) pos = i;
    end
    sb.insert(pos, x);
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%03h required=%03h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor for the main instance
  always @(negedge clk) begin
    exp_t x;
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        x = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse cyc=%0d actual=none required press=%b rel=%b evt=%b",
                 x.cyc, x.press, x.rel, x.evt);
      end
      if ((btn_press | btn_release | btn_event) != 3'b000) begin
        checks++;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          x = sb.pop_front();
          if ({btn_press, btn_release, btn_event, btn_level} !==
              {x.press, x.rel, x.evt, x.level}) begin
            errors++;
            $display("FAIL pulse_vec cyc=%0d actual p=%b r=%b e=%b l=%b required p=%b r=%b e=%b l=%b",
                     cyc, btn_press, btn_release, btn_event, btn_level,
                     x.press, x.rel, x.evt, x.level);
          end
        end else begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d actual p=%b r=%b e=%b required none",
                   cyc, btn_press, btn_release, btn_event);
        end
      end
    end
  end

  // Pulse tally for the repeat-disabled instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (nr_press[0]) begin
        nr_press_cnt++;
        nr_press_cyc = cyc;
      end
      if (nr_event[0])   nr_evt_cnt++;
      if (nr_release[0]) nr_rel_cnt++;
      if (nr_event[0] != nr_press[0]) nr_noncoin++;
    end
  end

  initial begin
    int         c;
    logic [6:0] pat;

    rst_n     = 1'b0;
    btn_in    = '0;
    btn_in_nr = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {btn_level, btn_press, btn_release, btn_event}, 12'h000);
    check("reset_outputs_nr", {nr_level, nr_press, nr_release, nr_event}, 12'h000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean press on ch0 with repeats, then a release with a one-cycle glitch
    c = cyc;
    btn_in[0] = 1'b1;
    push(c + 6, 3'b001, 3'b000, 3'b001, 3'b001);
    for (int k = 20; k <= 92; k += 8) push(c + 6 + k, 3'b000, 3'b000, 3'b001, 3'b001);
    push(c + 109, 3'b000, 3'b001, 3'b000, 3'b000);
    repeat (10) @(negedge clk);
    check("ch0_level_held", {9'd0, btn_level}, 12'h001);
    repeat (90) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (2) @(negedge clk);
    btn_in[0] = 1'b1;
    @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("ch0_level_glitch", {9'd0, btn_level}, 12'h001);
    repeat (10) @(negedge clk);
    check("ch0_level_released", {9'd0, btn_level}, 12'h000);

    // Bounce train on ch1: never four stable samples in a row
    pat = 7'b0111011;
    for (int i = 0; i < 7; i++) begin
      btn_in[1] = pat[i];
      @(negedge clk);
    end
    btn_in[1] = 1'b0;
    repeat (20) @(negedge clk);
    check("ch1_bounce_level", {9'd0, btn_level}, 12'h000);

    // Auto-repeat on ch2
    c = cyc;
    btn_in[2] = 1'b1;
    push(c + 6, 3'b100, 3'b000, 3'b100, 3'b100);
    for (int k = 20; k <= 52; k += 8) push(c + 6 + k, 3'b000, 3'b000, 3'b100, 3'b100);
    push(c + 66, 3'b000, 3'b100, 3'b000, 3'b000);
    repeat (60) @(negedge clk);
    btn_in[2] = 1'b0;
    repeat (15) @(negedge clk);

    // All three pressed, reset mid-repeat-count, buttons held through reset
    c = cyc;
    btn_in = 3'b111;
    push(c + 6, 3'b111, 3'b000, 3'b111, 3'b111);
    repeat (10) @(negedge clk);
    check("all_level_pressed", {9'd0, btn_level}, 12'h007);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {btn_level, btn_press, btn_release, btn_event}, 12'h000);
    repeat (3) @(negedge clk);
    check("reset_hold_outputs", {btn_level, btn_press, btn_release, btn_event}, 12'h000);
    rst_n = 1'b1;
    c = cyc;
    push(c + 6, 3'b111, 3'b000, 3'b111, 3'b111);
    push(c + 16, 3'b000, 3'b111, 3'b000, 3'b000);
    repeat (10) @(negedge clk);
    btn_in = 3'b000;
    repeat (15) @(negedge clk);

    // Repeat disabled: a 100-cycle hold gives a single event with the press
    c = cyc;
    btn_in_nr[0] = 1'b1;
    repeat (100) @(negedge clk);
    btn_in_nr[0] = 1'b0;
    repeat (15) @(negedge clk);
    check("nr_press_count", 12'(nr_press_cnt), 12'd1);
    check("nr_press_cycle", 12'(nr_press_cyc - c), 12'd6);
    check("nr_event_count", 12'(nr_evt_cnt), 12'd1);
    check("nr_event_coincident", 12'(nr_noncoin), 12'd0);
    check("nr_release_count", 12'(nr_rel_cnt), 12'd1);
    check("nr_level_final", {9'd0, nr_level}, 12'h000);

    repeat (5) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL leftover_expect cyc=%0d actual=none required press=%b rel=%b evt=%b",
               x.cyc, x.press, x.rel, x.evt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
